hood_mode_ctrl: RTL and testbench
=================================

# hood_mode_ctrl

Parametrised mode controller for the range-hood design. It generates its own 1 s tick and owns power on/off, including long-press power-off and two-hand gesture on/off. It also owns N suction levels, a time-limited storm level that is allowed once per power cycle, a post-storm drain countdown, self-clean, and accumulated-run-time reminder. It sits between the debounced button inputs and the display/fan/light outputs in the hood top level.

## Interface
Parameters:
- TICK_CYC, 100_000_000: clk cycles per 1 s tick
- LEVELS, 3: number of suction levels (1..LEVELS); level LEVELS is the storm level; must be ≥2
- STORM_SEC, 60: storm duration and drain duration, in s
- CLEAN_SEC, 180: self-clean duration, in s
- HOLD_SEC, 3: power-button hold time for power-off, in s
- GESTURE_SEC, 5: maximum gap between the two hand sensors, in s
- REMIND_SEC, 36000: accumulated run seconds that raise the reminder

Ports:
- Reset is synchronous, active-high.
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- btn_power  in  1  debounced power button (level)
- btn_hand_l, btn_hand_r  in  1  debounced gesture sensors (level)
- btn_level  in  LEVELS  level request; bit i selects level i+1
- btn_stop  in  1  stop fan request
- btn_clean  in  1  self-clean request
- power_on  out  1  1 in every state except OFF
- state  out  3  OFF=0, STANDBY=1, RUN=2, STORM=3, DRAIN=4, CLEAN=5
- level  out  $clog2(LEVELS+1)  current fan level; 0 = fan off
- remain_sec  out  16  countdown in STORM/DRAIN/CLEAN, otherwise 0
- work_sec  out  32  accumulated run seconds
- remind  out  1  work_sec ≥ REMIND_SEC
- tick  out  1  one-cycle 1 s pulse

## Operation
- **Edge detection:** every button passes through a rising-edge detector. The previous-value registers reset to 1, so a button held through reset produces no edge.
- **Prescaler:** counts 0..TICK_CYC-1; tick=1 on the wrap cycle. It is held at 0 in OFF and restarts at 0 on every state transition, so a countdown of N lasts exactly N·TICK_CYC cycles.
- **OFF → STANDBY** on either:
  - a btn_power edge, or
  - a gesture: btn_hand_l edge, then a btn_hand_r edge within GESTURE_SEC·TICK_CYC cycles.
- **Power-off, from any on state:**
  - Long press: a btn_power edge arms a hold counter; once btn_power has stayed high for HOLD_SEC·TICK_CYC cycles → OFF. Releasing the button disarms the counter. The press that powered the hood on never arms it.
  - Gesture off, STANDBY only: btn_hand_r edge, then btn_hand_l edge within the window → OFF.
  - A gesture window expires silently. A new first edge restarts the window.
- **Level requests, from STANDBY or RUN:**
  - bit i < LEVELS-1 → RUN at level i+1.
  - bit LEVELS-1 → STORM at level LEVELS, remain_sec=STORM_SEC, and storm_used is set. If storm_used is already set, the request is ignored.
  - If several bits rise in the same cycle, the highest index wins.
- **STORM:**
  - Level requests are ignored.
  - On expiry → RUN at level LEVELS-1.
  - btn_stop → DRAIN: level 1, remain_sec=STORM_SEC; on expiry → STANDBY.
- **RUN:** btn_stop → STANDBY immediately.
- **CLEAN:**
  - Entered only from STANDBY, on btn_clean.
  - level=0, remain_sec=CLEAN_SEC.
  - On expiry → STANDBY, with work_sec cleared to 0.
  - Requests other than power-off are ignored in CLEAN and DRAIN.
- **Countdown:** remain_sec loads on the state-entry cycle and decrements on each tick. The transition fires on the tick where remain_sec=1; remain_sec is 0 on exit.
- **Run-time counting:**
  - work_sec increments on each tick in RUN, STORM and DRAIN, and saturates at 2³²-1.
  - work_sec is kept through OFF; it is cleared only by reset or by CLEAN completion.
- **storm_used:** cleared on entry to OFF.
- **Priority within one cycle:** reset > long-press off > gesture off > btn_stop > countdown expiry > btn_clean > level request.

## Timing
- All outputs are registered. A state change appears on the cycle after the sampled edge or expiry tick.
- The gesture-on transition appears on the cycle after the second edge.
- **Reset** (also mid-countdown): on the next edge every output is 0; the gesture and hold counters and storm_used are cleared.
- remind updates combinationally from registered work_sec, i.e. in the same cycle as work_sec.
- level and remain_sec update in the same cycle as state.

## Test plan
All scenarios use TICK_CYC=4, LEVELS=3, STORM_SEC=3, CLEAN_SEC=2, HOLD_SEC=2, GESTURE_SEC=2, REMIND_SEC=5.

1. **Power on, long-press off:** btn_power pulse → state=1, power_on=1 one cycle after the edge. Then a new btn_power press held for 8 cycles → state=0, level=0. The same press released after 7 cycles → state stays 1.
2. **Gesture:** hand_l edge, then hand_r edge 5 cycles later → state=1. From STANDBY, hand_r edge then hand_l edge 9 cycles later → state stays 1.
3. **Storm once:** btn_level=3'b100 in STANDBY → state=3, level=3, remain_sec=3. After 12 cycles → state=2, level=2. A second 3'b100 edge → ignored. 3'b011 edges rising together → level=2.
4. **Drain:** enter STORM, btn_stop after 4 cycles → state=4, level=1, remain_sec=3. 12 cycles later → state=1, level=0. work_sec=4.
5. **Remind and clean:** in RUN for 20 cycles → work_sec=5, remind=1. Then btn_stop, btn_clean → state=5, remain_sec=2. 8 cycles later → state=1, work_sec=0, remind=0.
6. **Reset mid-clean:** reset during CLEAN → all outputs 0 the next cycle. A btn_power held high through reset produces no power-on.

Source files
------------

// File: rtl/hood_mode_ctrl.sv
// hood_mode_ctrl: range-hood power/level/storm/drain/clean mode controller with 1 s tick and run-time reminder
module hood_mode_ctrl #(
  parameter int TICK_CYC    = 100_000_000,
  parameter int LEVELS      = 3,
  parameter int STORM_SEC   = 60,
  parameter int CLEAN_SEC   = 180,
  parameter int HOLD_SEC    = 3,
  parameter int GESTURE_SEC = 5,
  parameter int REMIND_SEC  = 36000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           btn_power,
  input  logic                           btn_hand_l,
  input  logic                           btn_hand_r,
  input  logic [LEVELS-1:0]              btn_level,
  input  logic                           btn_stop,
  input  logic                           btn_clean,
  output logic                           power_on,
  output logic [2:0]                     state,
  output logic [$clog2(LEVELS+1)-1:0]    level,
  output logic [15:0]                    remain_sec,
  output logic [31:0]                    work_sec,
  output logic                           remind,
  output logic                           tick
);
  localparam int LW = $clog2(LEVELS + 1);
  localparam logic [31:0] T_LAST   = 32'(TICK_CYC - 1);
  localparam logic [31:0] HOLD_END = 32'(HOLD_SEC * TICK_CYC - 1);
  localparam logic [31:0] GEST_CYC = 32'(GESTURE_SEC * TICK_CYC);
  localparam logic [2:0] S_OFF = 3'd0, S_STANDBY = 3'd1, S_RUN = 3'd2, S_STORM = 3'd3, S_DRAIN = 3'd4, S_CLEAN = 3'd5;
  logic pow_q, hl_q, hr_q, stop_q, clean_q;
  logic [LEVELS-1:0] lvl_q, e_lvl;
  logic e_pow, e_hl, e_hr, e_stop, e_clean;
  logic [31:0] cnt, hold_cnt, g_cnt, work_n;
  logic armed, g_arm, storm_used;
  logic [2:0] state_n;
  logic [LW-1:0] level_n, req_lvl;
  logic [15:0] remain_n;
  logic on, cd, expire, long_off, g_first, g_hit, lvl_ok, track;
  assign e_pow   = btn_power & ~pow_q;
  assign e_hl    = btn_hand_l & ~hl_q;
  assign e_hr    = btn_hand_r & ~hr_q;
  assign e_stop  = btn_stop & ~stop_q;
  assign e_clean = btn_clean & ~clean_q;
  assign e_lvl   = btn_level & ~lvl_q;
  assign on       = state != S_OFF;
  assign cd       = state inside {S_STORM, S_DRAIN, S_CLEAN};
  assign expire   = cd && tick && remain_sec == 16'd1;
  assign long_off = on && armed && btn_power && hold_cnt == HOLD_END;
  assign g_first  = state == S_OFF ? e_hl : e_hr;
  assign g_hit    = g_arm && (state == S_OFF ? e_hr : e_hl);
  assign track    = state inside {S_OFF, S_STANDBY} && state_n == state;
  always_comb begin
    req_lvl = '0;
    for (int i = 0; i < LEVELS; i++) if (e_lvl[i]) req_lvl = LW'(i + 1);
  end
  assign lvl_ok = state inside {S_STANDBY, S_RUN} && req_lvl != '0 && !(req_lvl == LW'(LEVELS) && storm_used);
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_OFF;
      level      <= '0;
      remain_sec <= '0;
      work_sec   <= '0;
      cnt        <= '0;
      hold_cnt   <= '0;
      g_cnt      <= '0;
      armed      <= 1'b0;
      g_arm      <= 1'b0;
      storm_used <= 1'b0;
      {pow_q, hl_q, hr_q, stop_q, clean_q} <= '1;
      lvl_q      <= '1;
    end else begin
      state      <= state_n;
      level      <= level_n;
      remain_sec <= remain_n;
      work_sec   <= work_n;
      cnt        <= (state_n == S_OFF || state_n != state || tick) ? '0 : cnt + 32'd1;
      armed      <= on && state_n != S_OFF && (e_pow || (armed && btn_power));
      hold_cnt   <= e_pow ? 32'd1 : armed ? hold_cnt + 32'd1 : '0;
      g_arm      <= track && (g_first || (g_arm && g_cnt != GEST_CYC));
      g_cnt      <= g_first ? 32'd1 : g_arm ? g_cnt + 32'd1 : '0;
      storm_used <= state_n == S_OFF ? 1'b0 : (state_n == S_STORM || storm_used);
      {pow_q, hl_q, hr_q, stop_q, clean_q} <= {btn_power, btn_hand_l, btn_hand_r, btn_stop, btn_clean};
      lvl_q      <= btn_level;
    end
  end
  always_comb begin
    state_n  = state;
    level_n  = level;
    remain_n = (cd && tick) ? remain_sec - 16'd1 : remain_sec;
    work_n   = (tick && state inside {S_RUN, S_STORM, S_DRAIN} && ~&work_sec) ? work_sec + 32'd1 : work_sec;
    if (state == S_OFF) begin
      state_n = (e_pow || g_hit) ? S_STANDBY : S_OFF;
    end else if (long_off || (g_hit && state == S_STANDBY)) begin
      state_n  = S_OFF;
      level_n  = '0;
      remain_n = '0;
    end else if (e_stop && state == S_RUN) begin
      state_n = S_STANDBY;
      level_n = '0;
    end else if (e_stop && state == S_STORM) begin
      state_n  = S_DRAIN;
      level_n  = LW'(1);
      remain_n = 16'(STORM_SEC);
    end else if (expire) begin
      state_n  = state == S_STORM ? S_RUN : S_STANDBY;
      level_n  = state == S_STORM ? LW'(LEVELS - 1) : '0;
      remain_n = '0;
      work_n   = state == S_CLEAN ? '0 : work_n;
    end else if (e_clean && state == S_STANDBY) begin
      state_n  = S_CLEAN;
      level_n  = '0;
      remain_n = 16'(CLEAN_SEC);
    end else if (lvl_ok) begin
      state_n  = req_lvl == LW'(LEVELS) ? S_STORM : S_RUN;
      level_n  = req_lvl;
      remain_n = req_lvl == LW'(LEVELS) ? 16'(STORM_SEC) : '0;
    end
  end
  always_comb begin
    power_on = on;
    tick     = on && cnt == T_LAST;
    remind   = work_sec >= 32'(REMIND_SEC);
  end
endmodule

// File: tb/tb_hood_mode_ctrl.sv
// tb_hood_mode_ctrl: directed scoreboard bench for hood_mode_ctrl
module tb_hood_mode_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic btn_power = 1'b0, btn_hand_l = 1'b0, btn_hand_r = 1'b0, btn_stop = 1'b0, btn_clean = 1'b0;
  logic [2:0] btn_level = '0;
  logic power_on, remind, tick;
  logic [2:0] state;
  logic [1:0] level;
  logic [15:0] remain_sec;
  logic [31:0] work_sec;
  int cyc = 0, n_chk = 0, n_pass = 0;
  typedef struct { string name; int at; int st; int lvl; int rem; int wrk; int rmd; } exp_t;
  exp_t q[$];
  hood_mode_ctrl #(.TICK_CYC(4), .LEVELS(3), .STORM_SEC(3), .CLEAN_SEC(2), .HOLD_SEC(2), .GESTURE_SEC(2), .REMIND_SEC(5)) dut (
    .clk(clk), .reset(reset), .btn_power(btn_power), .btn_hand_l(btn_hand_l), .btn_hand_r(btn_hand_r),
    .btn_level(btn_level), .btn_stop(btn_stop), .btn_clean(btn_clean), .power_on(power_on), .state(state),
    .level(level), .remain_sec(remain_sec), .work_sec(work_sec), .remind(remind), .tick(tick)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void check(exp_t e);
    bit ok;
    ok = e.at == cyc && int'(state) == e.st && power_on == (e.st != 0) &&
         (e.lvl < 0 || int'(level) == e.lvl) && (e.rem < 0 || int'(remain_sec) == e.rem) &&
         (e.wrk < 0 || int'(work_sec) == e.wrk) && (e.rmd < 0 || int'(remind) == e.rmd);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s @%0d: got state=%0d pwr=%0d level=%0d remain=%0d work=%0d remind=%0d, want state=%0d level=%0d remain=%0d work=%0d remind=%0d (-1=any)",
                  e.name, cyc, state, power_on, level, remain_sec, work_sec, remind, e.st, e.lvl, e.rem, e.wrk, e.rmd);
  endfunction
  always @(negedge clk)
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].at <= cyc) begin
        check(q[i]);
        q.delete(i);
      end
  task automatic expect_at(input string nm, input int d, input int st, input int lvl = -1, input int rem = -1, input int wrk = -1, input int rmd = -1);
    exp_t e;
    e.name = nm; e.at = cyc + d; e.st = st; e.lvl = lvl; e.rem = rem; e.wrk = wrk; e.rmd = rmd;
    q.push_back(e);
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset;
    reset = 1'b1;
    {btn_power, btn_hand_l, btn_hand_r, btn_stop, btn_clean} = '0;
    btn_level = '0;
    expect_at("reset", 1, 0, 0, 0, 0, 0);
    step(2);
    reset = 1'b0;
    step(2);
  endtask
  task automatic power_up(input string nm);
    btn_power = 1'b1;
    expect_at(nm, 1, 1, 0, 0);
    step(1);
    btn_power = 1'b0;
    step(2);
  endtask
  initial begin
    step(1);
    do_reset;
    power_up("s1_on");
    btn_power = 1'b1;
    expect_at("s1_hold7", 7, 1);
    expect_at("s1_hold_off", 8, 0, 0, 0);
    step(8);
    btn_power = 1'b0;
    step(2);
    power_up("s1_on2");
    btn_power = 1'b1;
    step(7);
    btn_power = 1'b0;
    expect_at("s1_release7", 3, 1);
    step(4);
    do_reset;
    btn_hand_l = 1'b1;
    step(1);
    btn_hand_l = 1'b0;
    step(4);
    btn_hand_r = 1'b1;
    expect_at("s2_gest_on", 1, 1, 0, 0);
    step(1);
    btn_hand_r = 1'b0;
    step(2);
    btn_hand_r = 1'b1;
    step(1);
    btn_hand_r = 1'b0;
    step(8);
    btn_hand_l = 1'b1;
    expect_at("s2_gest_late", 2, 1);
    step(1);
    btn_hand_l = 1'b0;
    step(2);
    btn_hand_r = 1'b1;
    step(1);
    btn_hand_r = 1'b0;
    step(2);
    btn_hand_l = 1'b1;
    expect_at("s2_gest_off", 1, 0, 0, 0);
    step(1);
    btn_hand_l = 1'b0;
    step(2);
    do_reset;
    power_up("s3_on");
    btn_level = 3'b100;
    expect_at("s3_storm", 1, 3, 3, 3);
    expect_at("s3_storm_last", 12, 3, 3, 1);
    expect_at("s3_storm_run", 13, 2, 2, 0);
    step(1);
    btn_level = '0;
    step(13);
    btn_level = 3'b100;
    expect_at("s3_storm_again", 2, 2, 2, 0);
    step(1);
    btn_level = '0;
    step(2);
    btn_level = 3'b001;
    expect_at("s3_lvl1", 1, 2, 1, 0);
    step(1);
    btn_level = '0;
    step(1);
    btn_level = 3'b011;
    expect_at("s3_lvl_multi", 1, 2, 2, 0);
    step(1);
    btn_level = '0;
    step(2);
    do_reset;
    power_up("s4_on");
    btn_level = 3'b100;
    expect_at("s4_storm", 1, 3, 3, 3, 0);
    step(1);
    btn_level = '0;
    step(3);
    btn_stop = 1'b1;
    expect_at("s4_drain", 1, 4, 1, 3, 1);
    expect_at("s4_drain_last", 12, 4, 1, 1);
    expect_at("s4_standby", 13, 1, 0, 0, 4, 0);
    step(1);
    btn_stop = 1'b0;
    step(14);
    do_reset;
    power_up("s5_on");
    btn_level = 3'b001;
    expect_at("s5_run", 1, 2, 1, 0, 0, 0);
    expect_at("s5_work4", 20, 2, 1, 0, 4, 0);
    expect_at("s5_remind", 21, 2, 1, 0, 5, 1);
    step(1);
    btn_level = '0;
    step(20);
    btn_stop = 1'b1;
    expect_at("s5_stop", 1, 1, 0, 0, 5, 1);
    step(1);
    btn_stop = 1'b0;
    step(1);
    btn_clean = 1'b1;
    expect_at("s5_clean", 1, 5, 0, 2, 5, 1);
    expect_at("s5_clean_last", 8, 5, 0, 1, 5, 1);
    expect_at("s5_clean_done", 9, 1, 0, 0, 0, 0);
    step(1);
    btn_clean = 1'b0;
    step(10);
    do_reset;
    power_up("s6_on");
    btn_level = 3'b001;
    step(1);
    btn_level = '0;
    step(8);
    btn_stop = 1'b1;
    step(1);
    btn_stop = 1'b0;
    step(1);
    btn_clean = 1'b1;
    expect_at("s6_clean", 1, 5, 0, 2, 2, 0);
    step(1);
    btn_clean = 1'b0;
    step(2);
    reset = 1'b1;
    btn_power = 1'b1;
    expect_at("s6_reset", 1, 0, 0, 0, 0, 0);
    step(1);
    reset = 1'b0;
    step(3);
    expect_at("s6_no_edge", 1, 0, 0, 0, 0, 0);
    step(1);
    btn_power = 1'b0;
    step(5);
    foreach (q[i]) begin
      n_chk++;
      $display("FAIL %s: got no comparison, want one at cycle %0d", q[i].name, q[i].at);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
